// File: rtl/read_buffer_responder_pkg.sv
// rtl/read_buffer_responder_pkg.sv - shared state encoding and defaults for the read buffer responder
package read_buffer_pkg;

    localparam int RB_DATA_WIDTH = 16;
    localparam int RB_DEPTH      = 8;

    typedef enum logic [1:0] {
        RB_IDLE = 2'd0,
        RB_RESP = 2'd1,
        RB_GAP  = 2'd2
    } rb_state_t;

endpackage

// File: rtl/read_buffer_responder_if.sv
// rtl/read_buffer_responder_if.sv - producer push, status and controller request/response bundle
interface read_buffer_responder_if
    import read_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int DEPTH      = RB_DEPTH
);
    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     read_req_buffer;
    logic                     valid;
    logic [DATA_WIDTH-1:0]    data_out;

    modport slave (
        input  wr_en, wr_data, read_req_buffer,
        output full, empty, count, overflow, valid, data_out
    );

    modport master (
        output wr_en, wr_data, read_req_buffer,
        input  full, empty, count, overflow, valid, data_out
    );

endinterface

// File: rtl/read_buffer_responder_fifo.sv
// rtl/read_buffer_responder_fifo.sv - word FIFO with up/down occupancy counter and sticky overflow
module buffer_fifo_core #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inner_rst,
    input  logic                    i_push,
    input  logic                    i_pop,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still taken.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (inner_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
            if (i_push && !w_do_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/read_buffer_responder.sv
// rtl/read_buffer_responder.sv - answers each controller read request with one buffered word and a valid pulse
module read_buffer_responder
    import read_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int DEPTH      = RB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inner_rst,
    read_buffer_responder_if.slave   bus
);
    rb_state_t              r_state;
    logic                   r_valid;
    logic [DATA_WIDTH-1:0]  r_data_out;

    logic                   w_pop;
    logic                   w_empty;
    logic [DATA_WIDTH-1:0]  w_rd_data;

    assign w_pop = (r_state == RB_IDLE) && bus.read_req_buffer && !w_empty;

    buffer_fifo_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .inner_rst  (inner_rst),
        .i_push     (bus.wr_en),
        .i_pop      (w_pop),
        .i_wr_data  (bus.wr_data),
        .o_rd_data  (w_rd_data),
        .o_full     (bus.full),
        .o_empty    (w_empty),
        .o_count    (bus.count),
        .o_overflow (bus.overflow)
    );

    // GAP exists so a request still held high while valid is seen cannot trigger a second pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RB_IDLE;
            r_valid    <= 1'b0;
            r_data_out <= '0;
        end else if (inner_rst) begin
            r_state    <= RB_IDLE;
            r_valid    <= 1'b0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                RB_IDLE: begin
                    r_valid <= 1'b0;
                    if (w_pop) begin
                        r_data_out <= w_rd_data;
                        r_valid    <= 1'b1;
                        r_state    <= RB_RESP;
                    end
                end
                RB_RESP: begin
                    r_valid <= 1'b0;
                    r_state <= RB_GAP;
                end
                RB_GAP: begin
                    r_valid <= 1'b0;
                    r_state <= RB_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= RB_IDLE;
                end
            endcase
        end
    end

    assign bus.empty    = w_empty;
    assign bus.valid    = r_valid;
    assign bus.data_out = r_data_out;

endmodule
